// File: rtl/mvu_nloop_agu_if.sv
// rtl/mvu_nloop_agu_if.sv - address stream handshake between the AGU and its consumer
interface mvu_nloop_agu_if #(
  parameter int BADDR = 15,
  parameter int BLVL  = 3
);
  logic [BADDR-1:0] addr_out;
  logic [BLVL-1:0]  addr_level;
  logic             addr_valid;
  logic             addr_ready;

  modport master (output addr_out, output addr_level, output addr_valid, input addr_ready);
  modport slave  (input addr_out, input addr_level, input addr_valid, output addr_ready);
endinterface

// File: rtl/mvu_nloop_agu.sv
// rtl/mvu_nloop_agu.sv - nested-loop address generator, one address per cycle
module mvu_nloop_agu #(
  parameter int NLOOPS  = 5,
  parameter int BADDR   = 15,
  parameter int BJUMP   = 15,
  parameter int BLENGTH = 15,
  parameter int BCNTDWN = 29
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [BADDR-1:0]          base_addr,
  input  logic [NLOOPS*BJUMP-1:0]   jump,
  input  logic [NLOOPS*BLENGTH-1:0] length,
  input  logic [BCNTDWN-1:0]        countdown,
  mvu_nloop_agu_if.master           addr_if,
  output logic                      busy,
  output logic                      done
);
  localparam int BLVL = $clog2(NLOOPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [BJUMP-1:0]     jump_q    [NLOOPS];
  logic [BLENGTH-1:0]   len_q     [1:NLOOPS-1];
  logic [BLENGTH-1:0]   cnt       [1:NLOOPS-1];
  logic [BLENGTH-1:0]   cnt_nxt   [1:NLOOPS-1];
  logic [BCNTDWN-1:0]   remaining;
  logic [BLVL-1:0]      sel_lvl;
  logic                 found;
  logic signed [BJUMP-1:0] sel_jump;
  logic [BADDR-1:0]     addr_nxt;

  // Slice 0 of length has no loop counter behind it.
  wire unused_len0 = ^length[BLENGTH-1:0];

  // Lowest non-exhausted level picks the jump; everything below it reloads.
  always_comb begin
    found   = 1'b0;
    sel_lvl = BLVL'(NLOOPS - 1);
    for (int k = 1; k < NLOOPS; k++) begin
      if (!found && cnt[k] != '0) begin
        found   = 1'b1;
        sel_lvl = BLVL'(k - 1);
      end
    end
    sel_jump = jump_q[sel_lvl];
    addr_nxt = addr_if.addr_out + BADDR'(sel_jump);
    for (int k = 1; k < NLOOPS; k++) begin
      if (!found || int'(sel_lvl) >= k)
        cnt_nxt[k] = len_q[k];
      else if (int'(sel_lvl) == k - 1)
        cnt_nxt[k] = cnt[k] - BLENGTH'(1);
      else
        cnt_nxt[k] = cnt[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      addr_if.addr_out   <= '0;
      addr_if.addr_level <= '0;
      addr_if.addr_valid <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      remaining          <= '0;
      for (int k = 0; k < NLOOPS; k++) jump_q[k] <= '0;
      for (int k = 1; k < NLOOPS; k++) begin
        len_q[k] <= '0;
        cnt[k]   <= '0;
      end
    end else if (abort) begin
      state              <= IDLE;
      addr_if.addr_valid <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < NLOOPS; k++) jump_q[k] <= jump[k*BJUMP +: BJUMP];
            for (int k = 1; k < NLOOPS; k++) begin
              len_q[k] <= length[k*BLENGTH +: BLENGTH];
              cnt[k]   <= length[k*BLENGTH +: BLENGTH];
            end
            remaining <= countdown;
            if (countdown != '0) begin
              state              <= RUN;
              addr_if.addr_out   <= base_addr;
              addr_if.addr_level <= BLVL'(NLOOPS);
              addr_if.addr_valid <= 1'b1;
              busy               <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (addr_if.addr_valid && addr_if.addr_ready) begin
            if (remaining == BCNTDWN'(1)) begin
              state              <= DONE;
              addr_if.addr_valid <= 1'b0;
              busy               <= 1'b0;
              done               <= 1'b1;
              remaining          <= '0;
            end else begin
              remaining          <= remaining - BCNTDWN'(1);
              addr_if.addr_out   <= addr_nxt;
              addr_if.addr_level <= sel_lvl;
              for (int k = 1; k < NLOOPS; k++) cnt[k] <= cnt_nxt[k];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mvu_nloop_agu.sv
// tb/tb_mvu_nloop_agu.sv - self-checking bench for mvu_nloop_agu
module tb_mvu_nloop_agu;
  localparam int NL = 5;
  localparam int BA = 15;
  localparam int BJ = 15;
  localparam int BL = 15;
  localparam int BC = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  logic [BA-1:0]    base_addr = '0;
  logic [NL*BJ-1:0] jump = '0;
  logic [NL*BL-1:0] length = '0;
  logic [BC-1:0]    countdown = '0;
  logic busy, done;

  mvu_nloop_agu_if #(.BADDR(BA), .BLVL(3)) aif ();
  assign aif.addr_ready = ready;

  mvu_nloop_agu #(.NLOOPS(NL), .BADDR(BA), .BJUMP(BJ), .BLENGTH(BL), .BCNTDWN(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .jump(jump), .length(length), .countdown(countdown),
    .addr_if(aif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  int exp_addr[$];
  int exp_lvl[$];

  // Step i's level is the count of trailing odometer digits of (i-1) sitting at their maximum.
  function automatic void build(input int base, input int j[NL], input int l[NL], input int cd);
    int a, lvl;
    longint v, r;
    exp_addr.delete();
    exp_lvl.delete();
    if (cd == 0) return;
    a = base;
    exp_addr.push_back(a);
    exp_lvl.push_back(NL);
    for (int i = 1; i < cd; i++) begin
      v = i - 1;
      lvl = 0;
      for (int k = 1; k < NL; k++) begin
        r = l[k] + 1;
        if (v % r == l[k]) begin
          lvl++;
          v = v / r;
        end else break;
      end
      a = (a + j[lvl]) & 'h7FFF;
      exp_addr.push_back(a);
      exp_lvl.push_back(lvl);
    end
  endfunction

  task automatic drive_cfg(input int base, input int j[NL], input int l[NL], input int cd);
    base_addr = BA'(base);
    for (int k = 0; k < NL; k++) begin
      jump[k*BJ +: BJ]   = BJ'(j[k]);
      length[k*BL +: BL] = BL'(l[k]);
    end
    countdown = BC'(cd);
  endtask

  bit mon_en = 1'b0;
  int idx;
  bit done_exp, aborted, seen_done;
  int mon_cyc, done_cyc;
  bit ev;

  always @(negedge clk) begin
    if (mon_en) begin
      ev = (idx < exp_addr.size()) && !aborted;
      chk("valid", aif.addr_valid, ev);
      chk("busy", busy, ev);
      if (aif.addr_valid && ev) begin
        chk("addr", aif.addr_out, exp_addr[idx]);
        chk("level", aif.addr_level, exp_lvl[idx]);
      end
      chk("done", done, done_exp);
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = mon_cyc;
      end
      done_exp = 1'b0;
      if (abort) aborted = 1'b1;
      else if (aif.addr_valid && ready) begin
        idx++;
        done_exp = (idx == exp_addr.size());
      end
      mon_cyc++;
    end
  end

  task automatic run(input string tag, input int base, input int j[NL], input int l[NL], input int cd,
                     input int bp_addr, input int bp_n, input int abort_idx, output int dcyc);
    int bp_left, ab_cnt;
    bit fin;
    build(base, j, l, cd);
    drive_cfg(base, j, l, cd);
    idx = 0; aborted = 1'b0; seen_done = 1'b0; done_cyc = -1; mon_cyc = 0;
    done_exp = (cd == 0);
    bp_left = bp_n; ab_cnt = 0;
    start = 1'b1; ready = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mon_en = 1'b1;
    // Config changes after launch must not disturb the walk.
    base_addr = BA'($urandom);
    for (int k = 0; k < NL; k++) begin
      jump[k*BJ +: BJ]   = BJ'($urandom);
      length[k*BL +: BL] = BL'($urandom);
    end
    countdown = BC'($urandom);
    fin = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (seen_done || (aborted && ab_cnt >= 3)) begin
        fin = 1'b1;
        break;
      end
      if (bp_left > 0 && aif.addr_valid && aif.addr_out == BA'(bp_addr)) begin
        ready = 1'b0;
        bp_left--;
      end else ready = 1'b1;
      abort = (abort_idx >= 0) && !aborted && aif.addr_valid && (idx == abort_idx);
      start = aif.addr_valid;
      @(posedge clk); #1;
      if (aborted) ab_cnt++;
    end
    abort = 1'b0; start = 1'b0; ready = 1'b1;
    mon_en = 1'b0;
    chk({tag, "_finished"}, fin, 1);
    chk({tag, "_all_addrs"}, (abort_idx >= 0) ? idx : exp_addr.size(), (abort_idx >= 0) ? abort_idx : idx);
    dcyc = done_cyc;
  endtask

  int j40[NL]  = '{1, 10, 0, 0, 0};
  int l40[NL]  = '{7, 2, 100, 100, 100};
  int jw[NL]   = '{3, 0, 0, 0, 0};
  int jn[NL]   = '{-1, 0, 0, 0, 0};
  int l100[NL] = '{7, 100, 100, 100, 100};
  int jz[NL]   = '{0, 0, 0, 0, 5};
  int lz[NL]   = '{7, 0, 0, 0, 0};
  int dcyc;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #2;
    chk("rst_addr", aif.addr_out, 0);
    chk("rst_level", aif.addr_level, 0);
    chk("rst_valid", aif.addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #10;
    rst = 1'b0;

    build(100, j40, l40, 7);
    chk("model_nested_a3", exp_addr[3], 112);
    chk("model_nested_a6", exp_addr[6], 124);
    chk("model_nested_l3", exp_lvl[3], 1);
    run("nested", 100, j40, l40, 7, -1, 0, -1, dcyc);
    chk("nested_done_cyc", dcyc, 7);

    run("backpressure", 100, j40, l40, 7, 101, 3, -1, dcyc);
    chk("bp_done_cyc", dcyc, 10);

    build('h7FFE, jw, l100, 3);
    chk("model_wrap_a1", exp_addr[1], 1);
    run("wrap", 'h7FFE, jw, l100, 3, -1, 0, -1, dcyc);

    build(50, jn, l100, 3);
    chk("model_neg_a2", exp_addr[2], 48);
    run("negjump", 50, jn, l100, 3, -1, 0, -1, dcyc);

    run("cd0", 100, j40, l40, 0, -1, 0, -1, dcyc);
    chk("cd0_done_cyc", dcyc, 0);

    build(0, jz, lz, 3);
    chk("model_zero_l1", exp_lvl[1], 4);
    chk("model_zero_a2", exp_addr[2], 10);
    run("zerolen", 0, jz, lz, 3, -1, 0, -1, dcyc);

    run("abort", 100, j40, l40, 7, -1, 0, 2, dcyc);
    chk("abort_no_done", dcyc, -1);
    run("after_abort", 100, j40, l40, 7, -1, 0, -1, dcyc);
    chk("after_abort_done_cyc", dcyc, 7);

    drive_cfg(100, j40, l40, 7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && aif.addr_out != BA'(102); c++) begin
      @(posedge clk); #1;
    end
    chk("rst_reach_102", aif.addr_out, 102);
    #2 rst = 1'b1;
    #1;
    chk("midrst_addr", aif.addr_out, 0);
    chk("midrst_level", aif.addr_level, 0);
    chk("midrst_valid", aif.addr_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_done_held", done, 0);
    rst = 1'b0;
    run("after_rst", 100, j40, l40, 7, -1, 0, -1, dcyc);
    chk("after_rst_done_cyc", dcyc, 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mvu_nloop_agu.md
MVU_NLOOP_AGU -- requirements
Module: mvu_nloop_agu

Interface
REQ-001 SHALL have parameter NLOOPS, default 5: number of nested address loop levels, minimum 2.
REQ-002 SHALL have parameter BADDR, default 15: address width.
REQ-003 SHALL have parameter BJUMP, default 15: signed jump width.
REQ-004 SHALL have parameter BLENGTH, default 15: loop length width.
REQ-005 SHALL have parameter BCNTDWN, default 29: countdown width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: launch request, sampled in IDLE only.
REQ-009 SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-010 SHALL have port base_addr, input, BADDR bits: first address.
REQ-011 SHALL have port jump, input, NLOOPS*BJUMP bits: slice k is jump[k], two's complement.
REQ-012 SHALL have port length, input, NLOOPS*BLENGTH bits: slice k is length[k] for k=1..NLOOPS-1; slice 0 is unused.
REQ-013 SHALL have port countdown, input, BCNTDWN bits: total number of addresses to emit.
REQ-014 SHALL have port addr_out, output, BADDR bits: generated address.
REQ-015 SHALL have port addr_level, output, $clog2(NLOOPS+1) bits: index of the jump that produced addr_out; the value NLOOPS marks the first address.
REQ-016 SHALL have port addr_valid, output, 1 bit: addr_out and addr_level are valid.
REQ-017 SHALL have port addr_ready, input, 1 bit: consumer accepts.
REQ-018 SHALL have port busy, output, 1 bit: high in RUN.
REQ-019 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, RUN, DONE.
REQ-021 IDLE with start=1 at an edge SHALL latch base_addr, jump, length and countdown.
REQ-022 On that start edge, if countdown≠0: go to RUN, addr_valid=1, addr_out=base_addr, addr_level=NLOOPS, counters cnt[k]=length[k] (k≥1), remaining count=countdown.
REQ-023 On that start edge, if countdown=0: go to DONE; addr_valid SHALL never assert.
REQ-024 Handshake SHALL occur on an edge where addr_valid=1 and addr_ready=1.
REQ-025 While addr_valid=1 and addr_ready=0, addr_out and addr_level SHALL hold stable.
REQ-026 Each handshake SHALL decrement the remaining count; if it was 1, the block SHALL go to DONE with addr_valid=0.
REQ-027 Otherwise each handshake SHALL present the next address in the following cycle, giving one address per cycle at full throughput.
REQ-028 Next-address rule: s = smallest k in 1..NLOOPS-1 with cnt[k]≠0.
  - If s exists: addr += sign-extended jump[s-1]; cnt[s]--; cnt[1..s-1] reload to length; addr_level = s-1.
  - If no such k: addr += jump[NLOOPS-1]; all counters reload; addr_level = NLOOPS-1.
REQ-029 Address arithmetic SHALL be modulo 2^BADDR, with silent wrap and no flag.
REQ-030 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-031 busy SHALL be 1 in RUN only.
REQ-032 start SHALL be ignored in RUN and in DONE.
REQ-033 Config inputs changing during RUN SHALL have no effect.
REQ-034 abort=1 in any state SHALL force IDLE at the next edge with addr_valid=0, done=0, and no handshake counted.
REQ-035 abort SHALL take priority over start and over a simultaneous handshake.
REQ-036 A length[k] of 0 SHALL make level k exhausted every step.

Reset
REQ-037 rst=1 SHALL asynchronously force IDLE with addr_out=0, addr_level=0, addr_valid=0, busy=0, done=0, and all counters 0.
REQ-038 Reset mid-RUN SHALL discard the transfer; no done pulse SHALL follow.
REQ-039 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-040 Nested walk (defaults): base=100, jump0=1, jump1=10, length1=2, length2..4=100, countdown=7, ready=1 -> addr 100,101,102,112,113,114,124 on consecutive cycles; levels 5,0,0,1,0,0,1; done one cycle after the 7th handshake.
REQ-041 Wrap: base=0x7FFE, jump0=3, length1=100, countdown=3 -> addr 0x7FFE,0x0001,0x0004.
REQ-042 Negative jump: base=50, jump0=-1 (0x7FFF), length1=100, countdown=3 -> addr 50,49,48.
REQ-043 Backpressure: REQ-040 stimulus with ready=0 for 3 cycles while addr=101 -> addr 101 and valid held 3 cycles; sequence unchanged; done delayed by 3 cycles.
REQ-044 Edge cases:
  - countdown=0 -> done the cycle after start; valid never asserts.
  - All lengths 0, base=0, jump4=5, countdown=3 -> addr 0,5,10; levels 5,4,4.
REQ-045 Abort/reset: abort asserted during the 3rd address of REQ-040 -> IDLE next cycle, valid=0, no done, and a new start is accepted. Same test with rst instead -> outputs 0 immediately.
